dds_sweep_controller: RTL



---
 rtl/dds_sweep_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_controller.sv
// DDS command decoder: timed 128-bit commands drive the RFDC DDS register set,
// with an autonomous linear freq/amp sweep engine. One instance per DDS channel.
module dds_sweep_controller #(
    parameter int FREQ_WIDTH  = 48,
    parameter int AMP_WIDTH   = 14,
    parameter int PHASE_WIDTH = 14,
    parameter int TS_WIDTH    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [127:0]           cmd_data,
    input  logic                   sweep_abort,
    output logic [FREQ_WIDTH-1:0]  freq,
    output logic [AMP_WIDTH-1:0]   amp,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic [AMP_WIDTH-1:0]   amp_offset,
    output logic [TS_WIDTH-1:0]    time_offset,
    output logic [TS_WIDTH-1:0]    timestamp,
    output logic                   sync_en,
    output logic                   sweep_active,
    output logic                   sweep_done,
    output logic                   cmd_error
);

    localparam logic [3:0] OP_FREQ_HI   = 4'b0000;
    localparam logic [3:0] OP_FREQ_SYNC = 4'b0001;
    localparam logic [3:0] OP_FREQ_STEP = 4'b0010;
    localparam logic [3:0] OP_SWEEP     = 4'b0011;
    localparam logic [3:0] OP_TIME_OFS  = 4'b0100;
    localparam logic [3:0] OP_AMP_OFS   = 4'b0101;
    localparam logic [3:0] OP_AMP_STEP  = 4'b0110;
    localparam logic [3:0] OP_RESERVED  = 4'b0111;

    localparam int TOFS_W = (TS_WIDTH < 60) ? TS_WIDTH : 60;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state, state_next;
    logic                    live;
    logic                    accept;
    logic                    do_step;
    logic [3:0]              opcode;
    logic [59:0]             payload;

    logic [FREQ_WIDTH-1:0]   freq_step;
    logic signed [AMP_WIDTH:0] amp_step;
    logic [31:0]             sweep_cnt;
    logic [15:0]             dwell;
    logic [15:0]             dwell_cnt;

    int                      win_lsb;
    logic [FREQ_WIDTH-1:0]   win_mask;
    logic [FREQ_WIDTH-1:0]   freq_win;
    logic signed [AMP_WIDTH+1:0] amp_sum;
    logic [AMP_WIDTH-1:0]    amp_stepped;

    assign opcode  = cmd_data[63:60];
    assign payload = cmd_data[59:0];

    // live keeps cmd_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of process evaluation order.
            state <= state_next;
            live  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (otherwise a latch is inferred).
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && opcode == OP_SWEEP && payload[31:0] != 32'd0)
                    state_next = SWEEP;
            end
            SWEEP: begin
                if (sweep_abort)
                    state_next = IDLE;
                else if (dwell_cnt == 16'd0 && sweep_cnt == 32'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = live && (state == IDLE);
        sweep_active = (state == SWEEP);
        accept       = cmd_valid && cmd_ready;
        // Abort takes priority over a step due on the same edge.
        do_step      = (state == SWEEP) && !sweep_abort && (dwell_cnt == 16'd0);
    end

    // 32-bit freq write window: opcode 0000 hits the top bits, 1kkk starts two
    // bits lower and moves down two bits per k.
    always_comb begin
        win_lsb  = opcode[3] ? (FREQ_WIDTH - 34 - 2 * int'(opcode[2:0]))
                             : (FREQ_WIDTH - 32);
        win_mask = FREQ_WIDTH'(32'hFFFF_FFFF) << win_lsb;
        freq_win = (freq & ~win_mask) | (FREQ_WIDTH'(payload[31:0]) << win_lsb);
    end

    // Amplitude step saturates to [0, 2^AMP_WIDTH-1]; two guard bits hold sign and carry.
    always_comb begin
        amp_sum = $signed({2'b00, amp}) + $signed({amp_step[AMP_WIDTH], amp_step});
        if (amp_sum[AMP_WIDTH+1])
            amp_stepped = '0;
        else if (amp_sum[AMP_WIDTH])
            amp_stepped = '1;
        else
            amp_stepped = amp_sum[AMP_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq        <= '0;
            amp         <= '0;
            phase       <= '0;
            amp_offset  <= '0;
            time_offset <= '0;
            timestamp   <= '0;
            freq_step   <= '0;
            amp_step    <= '0;
            sweep_cnt   <= '0;
            dwell       <= '0;
            dwell_cnt   <= '0;
            sync_en     <= 1'b0;
            sweep_done  <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            sync_en    <= 1'b0;
            sweep_done <= 1'b0;
            cmd_error  <= 1'b0;
            if (accept) begin
                timestamp <= cmd_data[64 +: TS_WIDTH];
                case (opcode) inside
                    OP_FREQ_HI, 4'b1???: begin
                        freq  <= freq_win;
                        phase <= payload[32 +: PHASE_WIDTH];
                        amp   <= payload[46 +: AMP_WIDTH];
                    end
                    OP_FREQ_SYNC: begin
                        freq    <= FREQ_WIDTH'(payload[47:0]);
                        sync_en <= 1'b1;
                    end
                    OP_FREQ_STEP: freq_step <= FREQ_WIDTH'($signed(payload[47:0]));
                    OP_SWEEP: begin
                        sweep_cnt <= payload[31:0];
                        dwell     <= payload[47:32];
                        dwell_cnt <= payload[47:32];
                        // A zero-length sweep completes immediately without stepping.
                        if (payload[31:0] == 32'd0)
                            sweep_done <= 1'b1;
                    end
                    OP_TIME_OFS: time_offset[TOFS_W-1:0] <= payload[TOFS_W-1:0];
                    OP_AMP_OFS:  amp_offset <= payload[AMP_WIDTH-1:0];
                    OP_AMP_STEP: amp_step   <= payload[AMP_WIDTH:0];
                    OP_RESERVED: cmd_error  <= 1'b1;
                    default: ;
                endcase
            end else if (do_step) begin
                freq      <= freq + freq_step;
                amp       <= amp_stepped;
                sweep_cnt <= sweep_cnt - 32'd1;
                dwell_cnt <= dwell;
                if (sweep_cnt == 32'd1)
                    sweep_done <= 1'b1;
            end else if (state == SWEEP && !sweep_abort) begin
                dwell_cnt <= dwell_cnt - 16'd1;
            end
        end
    end

endmodule
